// File: rtl/cache_ctrl_if.sv
// Processor-side and main-memory-side buses of the cache_ctrl sequencing controller.
// Handshakes: the processor holds Req with RWB/Address/WData stable until a one-cycle Ready
// completes it; the controller holds mem_req with mem_* stable until mem_ack, and mem_ack
// counts only in a cycle where mem_req is high.
interface cache_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              Req;
  logic              RWB;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WData;
  logic [DATA_W-1:0] RData;
  logic              Ready;
  logic              Hit;
  logic              Busy;
  logic              mem_req;
  logic              mem_rwb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output Req, RWB, Address, WData, mem_rdata, mem_ack,
                  input  RData, Ready, Hit, Busy, mem_req, mem_rwb, mem_addr, mem_wdata);
  modport slave  (input  Req, RWB, Address, WData, mem_rdata, mem_ack,
                  output RData, Ready, Hit, Busy, mem_req, mem_rwb, mem_addr, mem_wdata);
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller: one processor request
// at a time, multi-beat line fill on read miss, every write forwarded to main memory.
module cache_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 2,
  parameter int OFFSET_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  cache_ctrl_if.slave   bus,
  output logic [2:0]    o_dbg_state
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP, S_WTHRU} state_t;

  state_t              r_state, w_next;
  logic                r_rwb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [OFFSET_W-1:0] r_beat;
  logic                r_hit;
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES][WORDS];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_hit_out;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic                w_lookup_hit;
  logic                w_last_beat;
  logic                w_ready;
  logic                w_hit_now;
  logic [DATA_W-1:0]   w_rdata_now;
  logic                w_mem_req;
  logic                w_mem_rwb;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;

  assign w_tag        = r_addr[ADDR_W-1 -: TAG_W];
  assign w_index      = r_addr[OFFSET_W +: INDEX_W];
  assign w_offset     = r_addr[OFFSET_W-1:0];
  assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last_beat  = (r_beat == OFFSET_W'(WORDS - 1));

  // Ready is decoded in the completing state so a processor still holding Req in the
  // Ready cycle is never mistaken for a new request.
  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_hit_now   = r_hit_out;
    w_rdata_now = r_rdata;
    w_mem_req   = 1'b0;
    w_mem_rwb   = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.Req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!r_rwb) begin
          w_next = S_WTHRU;
        end else if (w_lookup_hit) begin
          w_ready     = 1'b1;
          w_hit_now   = 1'b1;
          w_rdata_now = r_data[w_index][w_offset];
          w_next      = S_IDLE;
        end else begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        w_mem_req  = 1'b1;
        w_mem_rwb  = 1'b1;
        w_mem_addr = {w_tag, w_index, r_beat};
        if (bus.mem_ack && w_last_beat) w_next = S_RESP;
      end
      S_RESP: begin
        w_ready     = 1'b1;
        w_hit_now   = 1'b0;
        w_rdata_now = r_data[w_index][w_offset];
        w_next      = S_IDLE;
      end
      S_WTHRU: begin
        w_mem_req   = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        if (bus.mem_ack) begin
          w_ready   = 1'b1;
          w_hit_now = r_hit;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rwb     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_beat    <= '0;
      r_hit     <= 1'b0;
      r_valid   <= '0;
      r_rdata   <= '0;
      r_hit_out <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ready) begin
        r_rdata   <= w_rdata_now;
        r_hit_out <= w_hit_now;
      end
      case (r_state)
        S_IDLE: begin
          r_beat <= '0;
          if (bus.Req) begin
            r_rwb   <= bus.RWB;
            r_addr  <= bus.Address;
            r_wdata <= bus.WData;
          end
        end
        S_LOOKUP: r_hit <= w_lookup_hit;
        S_FILL: begin
          if (bus.mem_ack) begin
            r_beat <= r_beat + OFFSET_W'(1);
            // The line becomes valid only once its final beat lands.
            if (w_last_beat) begin
              r_tag[w_index]   <= w_tag;
              r_valid[w_index] <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_LOOKUP && !r_rwb && w_lookup_hit)
        r_data[w_index][w_offset] <= r_wdata;
      else if (r_state == S_FILL && bus.mem_ack)
        r_data[w_index][r_beat] <= bus.mem_rdata;
    end
  end

  assign bus.Ready     = w_ready;
  assign bus.Hit       = w_hit_now;
  assign bus.RData     = w_rdata_now;
  assign bus.Busy      = (r_state != S_IDLE);
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_rwb   = w_mem_rwb;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl: a line-residency model predicts hits, memory
// traffic and read data; a memory responder and a Ready monitor check against queues.
module tb_cache_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  cache_ctrl_if #(.ADDR_W(6), .DATA_W(8)) bus ();

  cache_ctrl #(.ADDR_W(6), .DATA_W(8), .INDEX_W(2), .OFFSET_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0]  exp_q[$];      // {is_read, hit, rdata}
  logic [14:0] exp_mem_q[$];  // {rwb, addr, wdata}
  logic [7:0]  ext_mem   [64];
  logic [7:0]  model_mem [64];
  int          resident  [4]; // block number held by each line, -1 if none
  int          ack_lat   = 1;
  int          ack_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Main memory: acks each beat after ack_lat cycles of mem_req, checks the request.
  initial begin : mem_resp
    int waited;
    logic [14:0] e;
    waited = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        waited++;
        if (waited >= ack_lat) begin
          waited = 0;
          check("mem_op_expected", int'(exp_mem_q.size() > 0), 1);
          if (exp_mem_q.size() > 0) begin
            e = exp_mem_q.pop_front();
            check("mem_rwb", bus.mem_rwb, e[14]);
            check("mem_addr", bus.mem_addr, e[13:8]);
            if (!e[14]) check("mem_wdata", bus.mem_wdata, e[7:0]);
          end
          if (bus.mem_rwb) bus.mem_rdata = ext_mem[bus.mem_addr];
          else             ext_mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_ack = 1'b1;
          ack_count++;
        end
      end else begin
        waited = 0;
      end
    end
  end

  // Ready monitor and output-hold checks.
  initial begin : monitor
    logic       prev_ready, hold_hit, last_read;
    logic [7:0] hold_rdata;
    logic [9:0] e;
    prev_ready = 1'b0; hold_hit = 1'b0; last_read = 1'b1; hold_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ready = 1'b0; hold_hit = 1'b0; last_read = 1'b1; hold_rdata = '0;
      end else begin
        if (!bus.mem_ack && exp_mem_q.size() == 0) check("mem_req_unexpected", bus.mem_req, 0);
        if (exp_q.size() == 0) begin
          check("ready_unexpected", bus.Ready, 0);
        end else if (bus.Ready) begin
          check("ready_twice", prev_ready, 0);
          check("busy_at_ready", bus.Busy, 1);
          e = exp_q.pop_front();
          check("hit", bus.Hit, e[8]);
          hold_hit  = e[8];
          last_read = e[9];
          if (e[9]) begin
            check("rdata", bus.RData, e[7:0]);
            hold_rdata = e[7:0];
          end
        end
        if (!bus.Ready) begin
          check("hit_hold", bus.Hit, hold_hit);
          if (last_read) check("rdata_hold", bus.RData, hold_rdata);
        end
        prev_ready = bus.Ready;
      end
    end
  end

  // Issue one request from IDLE, predict its outcome, hold Req until Ready.
  task automatic do_req(input logic rwb, input logic [5:0] a, input logic [7:0] d, input bit pulse);
    int   blk, line, n;
    logic exp_hit;
    bit   got;
    blk = int'(a) >> 2;
    line = blk % 4;
    exp_hit = (resident[line] == blk);
    n = 0;
    got = 1'b0;
    if (rwb) begin
      exp_q.push_back({1'b1, exp_hit, model_mem[a]});
      if (!exp_hit) begin
        for (int b = 0; b < 4; b++) exp_mem_q.push_back({1'b1, 6'(blk * 4 + b), 8'h00});
        resident[line] = blk;
      end
    end else begin
      exp_q.push_back({1'b0, exp_hit, 8'h00});
      exp_mem_q.push_back({1'b0, a, d});
      model_mem[a] = d;
    end
    bus.Req = 1'b1; bus.RWB = rwb; bus.Address = a; bus.WData = d;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.Ready) begin
        got = 1'b1;
      end else if (n >= 2) begin
        check("busy", bus.Busy, 1);
        if (pulse) bus.Req = 1'($urandom_range(0, 1));
      end
    end
    check("ready_seen", got, 1);
    if (got && rwb && exp_hit) check("hit_latency", n, 2);
    @(posedge clk); #1;
    bus.Req = 1'b0;
  endtask

  // Start a fill with slow acks and reset while beat 2 is outstanding.
  task automatic reset_during_fill(input logic [5:0] a);
    int base, n, blk;
    blk = int'(a) >> 2;
    n = 0;
    ack_lat = 3;
    for (int b = 0; b < 4; b++) exp_mem_q.push_back({1'b1, 6'(blk * 4 + b), 8'h00});
    base = ack_count;
    bus.Req = 1'b1; bus.RWB = 1'b1; bus.Address = a; bus.WData = '0;
    while (ack_count < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("fill_beats_before_reset", ack_count - base, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_mem_req", bus.mem_req, 0);
    check("abort_busy", bus.Busy, 0);
    check("abort_ready", bus.Ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_mem_q.delete();
    for (int i = 0; i < 4; i++) resident[i] = -1;
  endtask

  initial begin : stim
    logic [5:0] ra;
    logic [7:0] rd;
    logic       rrw;
    bit         rp;
    reset = 1'b1;
    bus.Req = 1'b0; bus.RWB = 1'b1; bus.Address = '0; bus.WData = '0;
    for (int i = 0; i < 64; i++) begin
      ext_mem[i]   = 8'(i) ^ 8'hA5;
      model_mem[i] = 8'(i) ^ 8'hA5;
    end
    for (int i = 0; i < 4; i++) resident[i] = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.Ready, 0);
    check("rst_hit", bus.Hit, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_rwb", bus.mem_rwb, 0);
    check("rst_rdata", bus.RData, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    ack_lat = 1;
    do_req(1'b1, 6'h13, 8'h00, 1'b0);  // cold miss, fill 0x10-0x13
    do_req(1'b1, 6'h12, 8'h00, 1'b0);  // hit
    do_req(1'b0, 6'h12, 8'h5C, 1'b0);  // write hit
    do_req(1'b1, 6'h12, 8'h00, 1'b0);
    do_req(1'b0, 6'h33, 8'h77, 1'b0);  // write miss, no allocate
    do_req(1'b1, 6'h33, 8'h00, 1'b0);
    do_req(1'b1, 6'h23, 8'h00, 1'b0);  // conflict evicts block 0x30
    do_req(1'b1, 6'h13, 8'h00, 1'b0);

    reset_during_fill(6'h25);
    ack_lat = 2;
    do_req(1'b1, 6'h25, 8'h00, 1'b1);  // partial line must not have become valid
    do_req(1'b1, 6'h26, 8'h00, 1'b1);

    for (int i = 0; i < 150; i++) begin
      ra = {2'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      rd = 8'($urandom_range(0, 255));
      rrw = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      ack_lat = $urandom_range(1, 4);
      do_req(rrw, ra, rd, rp);
    end

    repeat (4) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_mem_q_drained", exp_mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
